// File: rtl/fanout_bcast_buf.sv
// Broadcast buffer: a small circular queue whose head word is offered to every load and popped once all have taken it.
// Optional stall cycle counter enabled by defining FANOUT_BCAST_STALL_CNT_EN.
module fanout_bcast_buf #(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 4,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_LOADS-1:0]       out_valid,
  input  logic [NUM_LOADS-1:0]       out_ready,
  output logic [NUM_LOADS*WIDTH-1:0] out_data
`ifdef FANOUT_BCAST_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_LOADS-1:0] done_q, done_d;
  logic [NUM_LOADS-1:0] xfer;
  logic                 push, pop, not_empty;

  always_comb begin
    not_empty = (count_q != '0);
    in_ready  = (count_q != DEPTH_C);
    out_valid = {NUM_LOADS{not_empty}} & ~done_q;
    xfer      = out_valid & out_ready;
    push      = in_valid && in_ready;
    // Loads already done count as satisfied, so the head leaves once the last straggler takes it.
    pop       = not_empty && (&(done_q | xfer));
    done_d    = pop ? '0 : (done_q | xfer);

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  for (genvar gi = 0; gi < NUM_LOADS; gi++) begin : g_copy
    assign out_data[gi*WIDTH +: WIDTH] = mem_q[rd_ptr_q];
  end

`ifdef FANOUT_BCAST_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (not_empty && (|(out_valid & ~out_ready)) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fanout_bcast_buf.sv
// Bench for fanout_bcast_buf: vector table, per-load scoreboard queues, reset and stream sequences.
module tb_fanout_bcast_buf;

  localparam int W  = 8;
  localparam int NL = 4;
  localparam int DP = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [NL-1:0]  out_valid;
  logic [NL-1:0]  out_ready;
  logic [NL*W-1:0] out_data;
`ifdef FANOUT_BCAST_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  fanout_bcast_buf #(.WIDTH(W), .NUM_LOADS(NL), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FANOUT_BCAST_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: per-load queues of words still owed to that load.
  logic [W-1:0]  exp_q [NL][$];
  int            m_count = 0;
  logic [NL-1:0] m_done  = '0;
  logic          s_ready;
  logic [NL-1:0] s_valid;

  typedef struct packed {
    logic          iv;
    logic [W-1:0]  id;
    logic [NL-1:0] ordy;
    logic          ready;
    logic [NL-1:0] valid;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NL; k++) exp_q[k].delete();
    m_count = 0;
    m_done  = '0;
  endtask

  // Drive one cycle of stimulus, check outputs at the falling edge, advance the model.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic [NL-1:0] ordy);
    logic          mready;
    logic [NL-1:0] mvalid, xfer;
    logic [W-1:0]  want;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    s_ready = in_ready;
    s_valid = out_valid;
    mready  = (m_count != DP);
    mvalid  = (m_count != 0) ? ~m_done : '0;
    chk("in_ready", {31'd0, in_ready}, {31'd0, mready});
    chk("out_valid", {28'd0, out_valid}, {28'd0, mvalid});
    xfer = mvalid & ordy;
    for (int k = 0; k < NL; k++) begin
      if (xfer[k]) begin
        if (exp_q[k].size() == 0) begin
          chk("extra_word", {24'd0, out_data[k*W +: W]}, 32'hFFFF_FFFF);
        end else begin
          want = exp_q[k].pop_front();
          chk("out_data", {24'd0, out_data[k*W +: W]}, {24'd0, want});
        end
      end
    end
    if (m_count != 0 && (&(m_done | xfer))) begin
      m_count--;
      m_done = '0;
    end else begin
      m_done = m_done | xfer;
    end
    if (iv && mready) begin
      for (int k = 0; k < NL; k++) exp_q[k].push_back(id);
      m_count++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;

    // iv, data, out_ready, expected in_ready, expected out_valid
    tbl[0]  = '{1'b1, 8'hA5, 4'h0, 1'b1, 4'h0};
    tbl[1]  = '{1'b0, 8'h00, 4'hF, 1'b1, 4'hF};
    tbl[2]  = '{1'b0, 8'h00, 4'h0, 1'b1, 4'h0};
    tbl[3]  = '{1'b1, 8'h3C, 4'h0, 1'b1, 4'h0};
    tbl[4]  = '{1'b0, 8'h00, 4'h1, 1'b1, 4'hF};
    tbl[5]  = '{1'b0, 8'h00, 4'h6, 1'b1, 4'hE};
    tbl[6]  = '{1'b0, 8'h00, 4'h8, 1'b1, 4'h8};
    tbl[7]  = '{1'b0, 8'h00, 4'hF, 1'b1, 4'h0};
    tbl[8]  = '{1'b1, 8'h01, 4'h0, 1'b1, 4'h0};
    tbl[9]  = '{1'b1, 8'h02, 4'h0, 1'b1, 4'hF};
    tbl[10] = '{1'b1, 8'h03, 4'h0, 1'b0, 4'hF};
    tbl[11] = '{1'b0, 8'h00, 4'hF, 1'b0, 4'hF};
    tbl[12] = '{1'b0, 8'h00, 4'hF, 1'b1, 4'hF};
    tbl[13] = '{1'b0, 8'h00, 4'h0, 1'b1, 4'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk($sformatf("vec%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].ready});
      chk($sformatf("vec%0d_valid", i), {28'd0, s_valid}, {28'd0, tbl[i].valid});
      $display("vec %0d: iv=%b data=%h ordy=%h in_ready=%b out_valid=%h", i, tbl[i].iv, tbl[i].id, tbl[i].ordy, s_ready, s_valid);
    end

    // Back-to-back stream with every load ready: one word per cycle.
    for (int i = 0; i < 17; i++) begin
      step(i < 16, 8'(8'h10 + i), 4'hF);
      if (i > 0) chk("stream_valid", {28'd0, s_valid}, 32'hF);
      chk("stream_ready", {31'd0, s_ready}, 32'd1);
      $display("stream %0d: in_ready=%b out_valid=%h", i, s_ready, s_valid);
    end
    step(1'b0, 8'h00, 4'hF);
    chk("stream_drained", {28'd0, s_valid}, 32'h0);

    // Reset while two words are queued and loads 0,1 are already done.
    step(1'b1, 8'hB1, 4'h0);
    step(1'b1, 8'hB2, 4'b0011);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {28'd0, out_valid}, 32'd0);
    $display("mid-reset: in_ready=%b out_valid=%h", in_ready, out_valid);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 4'hF);
      chk("postrst_valid", {28'd0, s_valid}, 32'h0);
    end
    step(1'b1, 8'h77, 4'hF);
    step(1'b0, 8'h00, 4'hF);
    chk("postrst_new_word", {28'd0, s_valid}, 32'hF);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 4'hF);
    for (int k = 0; k < NL; k++) chk($sformatf("leftover_load%0d", k), exp_q[k].size(), 32'd0);
    $display("random phase: total=%0d", total);

`ifdef FANOUT_BCAST_STALL_CNT_EN
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("stall_reset", {16'd0, stall_cnt}, 32'd0);
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    out_ready = 4'b1011;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_five", {16'd0, stall_cnt}, 32'd5);
    $display("stall: cnt=%h", stall_cnt);
    repeat (65534 - 5) @(posedge clk);
    #1;
    chk("stall_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    $display("stall: cnt=%h", stall_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fanout_bcast_buf.md
FANOUT_BCAST_BUF -- requirements
Module: fanout_bcast_buf

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per word.
REQ-002 SHALL provide parameter NUM_LOADS, default 4, broadcast load count, legal range 1..16.
REQ-003 SHALL provide parameter DEPTH, default 2, entries in the input queue, legal range 1..16.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_ready  output  1  queue accepts a word this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream word.
REQ-009 SHALL have port out_valid  output  NUM_LOADS  per-load head word pending.
REQ-010 SHALL have port out_ready  input  NUM_LOADS  per-load accept.
REQ-011 SHALL have port out_data  output  NUM_LOADS*WIDTH  per-load copy of the head word, load k in bits [k*WIDTH +: WIDTH].

Function
REQ-012 SHALL store words in a circular queue of DEPTH entries, with occupancy count width clog2(DEPTH+1) and wrapping read/write pointers.
REQ-013 SHALL push a word when in_valid && in_ready, and SHALL drive in_ready = (count != DEPTH), with no same-cycle pop credit.
REQ-014 SHALL drive out_data of every load from the register output of the queue head entry, with no combinational path from in_data, giving a minimum latency of 1 cycle from push to out_valid.
REQ-015 SHALL keep a NUM_LOADS-bit done mask, and SHALL drive out_valid[k] = (count != 0) && !done[k].
REQ-016 SHALL complete a transfer to load k when out_valid[k] && out_ready[k].
REQ-017 SHALL pop the head in the cycle where every load is either done or transferring.
REQ-018 SHALL clear the done mask on pop, otherwise OR the done mask with this cycle's transfers.
REQ-019 SHALL let loads accept the same head in different cycles, and SHALL present each word to each load exactly once, in push order.
REQ-020 SHALL perform both push and pop when they occur in the same cycle with count between 1 and DEPTH-1, leaving count unchanged.
REQ-021 SHALL permit a push in the same cycle as a pop when count == DEPTH-1 or lower; when count == DEPTH, in_ready is 0 regardless of the pop.
REQ-022 SHALL ignore out_ready while out_valid[k] is 0, and SHALL ignore in_data while the push condition is false.

Reset
REQ-023 SHALL, when rst_n is asserted, asynchronously clear count, both pointers and the done mask, and force out_valid to all-zero and in_ready to 1 (out_data content is don't-care).
REQ-024 SHALL, when reset is asserted mid-transfer, discard queued words and the partial done mask; after deassertion no pre-reset word reappears.
REQ-025 SHALL treat rst_n deassertion as synchronised externally; no internal reset synchroniser.

Configuration
REQ-026 SHALL, when macro FANOUT_BCAST_STALL_CNT_EN is defined, add output stall_cnt, 16 bits, counting cycles where count != 0 and some load k has out_valid[k] && !out_ready[k], saturating at 16'hFFFF, cleared by reset.
REQ-027 SHALL, when FANOUT_BCAST_STALL_CNT_EN is undefined, omit the stall_cnt port and its counter entirely, with all other behaviour identical.

Verification
REQ-028 SHALL cover single word, all loads ready: push 8'hA5 at cycle 0 -> out_valid=4'hF at cycle 1 with all four copies 8'hA5, popped at cycle 1, out_valid=0 at cycle 2.
REQ-029 SHALL cover staggered accept: push 8'h3C; out_ready=0001, then 0110, then 1000 on successive cycles -> each load sees exactly one transfer; pop occurs on the third cycle; done mask clears.
REQ-030 SHALL cover full/backpressure (DEPTH=2): out_ready=0, push 8'h01 and 8'h02 -> in_ready=0 after the second push; a third in_valid is not accepted; release out_ready=F -> 01 then 02 delivered in order, and in_ready returns to 1.
REQ-031 SHALL cover simultaneous push/pop at count=1: continuous stream 8'h10..8'h1F with out_ready=F -> one word per cycle, count held at 1, no drops or duplicates.
REQ-032 SHALL cover reset mid-operation: two words queued with done=0011, assert rst_n low for 1 cycle -> out_valid=0 and in_ready=1 immediately; after release no old word is presented.
REQ-033 SHALL cover FANOUT_BCAST_STALL_CNT_EN defined: hold load 2 not ready for 5 cycles with a head pending -> stall_cnt=5; preload 16'hFFFE and stall 3 cycles -> stall_cnt=16'hFFFF.
